// File: rtl/alu_rs_pkg.sv
// Shared types for the integer ALU reservation station: widths, opcode
// enumeration, entry record and the CDB operand capture helper.
package alu_rs_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RS_ROB_W = 4;
  localparam int unsigned RS_OPT_W = 6;

  localparam logic [RS_ROB_W-1:0] ROB_NONE = '0;

  typedef enum logic [RS_OPT_W-1:0] {
    OPT_NOP = 6'd0,
    OPT_ADD, OPT_SUB, OPT_AND, OPT_OR, OPT_XOR,
    OPT_SLL, OPT_SRL, OPT_SRA, OPT_SLT, OPT_SLTU,
    OPT_ADDI, OPT_ANDI, OPT_ORI, OPT_XORI,
    OPT_SLLI, OPT_SRLI, OPT_SRAI, OPT_SLTI, OPT_SLTIU,
    OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR,
    OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU
  } opt_e;

  typedef struct packed {
    logic [XLEN-1:0]     val;
    logic [RS_ROB_W-1:0] dep;
  } rs_opnd_t;

  typedef struct packed {
    logic                busy;
    logic [RS_OPT_W-1:0] opt;
    rs_opnd_t            op1;
    rs_opnd_t            op2;
    logic [XLEN-1:0]     imm;
    logic [RS_ROB_W-1:0] rob_idx;
  } rs_entry_t;

  // Capture a waiting operand from the CDB; the ALU source has priority.
  function automatic rs_opnd_t wake_opnd(
    input rs_opnd_t            cur,
    input logic                alu_v,
    input logic [RS_ROB_W-1:0] alu_src,
    input logic [XLEN-1:0]     alu_val,
    input logic                lsu_v,
    input logic [RS_ROB_W-1:0] lsu_src,
    input logic [XLEN-1:0]     lsu_val
  );
    rs_opnd_t res;
    res = cur;
    if (cur.dep != ROB_NONE) begin
      if (alu_v && (cur.dep == alu_src)) begin
        res.val = alu_val;
        res.dep = ROB_NONE;
      end else if (lsu_v && (cur.dep == lsu_src)) begin
        res.val = lsu_val;
        res.dep = ROB_NONE;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Lowest-index priority encoder used for free-slot and ready-entry search.
module rs_select #(
  parameter  int unsigned N  = 8,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station: buffers dispatched ops, wakes operands
// from the CDB and issues the lowest-index ready entry each cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ROB_W = 4,
  parameter int unsigned OPT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rob_flush,
  input  logic             disp_valid,
  input  logic [OPT_W-1:0] disp_opt,
  input  logic [31:0]      disp_val1,
  input  logic [31:0]      disp_val2,
  input  logic [31:0]      disp_imm,
  input  logic [ROB_W-1:0] disp_dep1,
  input  logic [ROB_W-1:0] disp_dep2,
  input  logic [ROB_W-1:0] disp_rob_idx,
  output logic             rs_full,
  input  logic             cdb_alu_valid,
  input  logic             cdb_lsu_valid,
  input  logic [ROB_W-1:0] cdb_alu_src,
  input  logic [ROB_W-1:0] cdb_lsu_src,
  input  logic [31:0]      cdb_alu_val,
  input  logic [31:0]      cdb_lsu_val,
  output logic             rs_valid,
  output logic [OPT_W-1:0] rs_opt,
  output logic [31:0]      rs_val1,
  output logic [31:0]      rs_val2,
  output logic [31:0]      rs_imm,
  output logic [ROB_W-1:0] rs_rob_idx
);

  localparam int unsigned IW = $clog2(DEPTH);

  rs_entry_t             ent_q    [DEPTH];
  rs_entry_t             ent_wake [DEPTH];
  rs_entry_t             disp_ent;
  logic [DEPTH-1:0]      busy_vec;
  logic [DEPTH-1:0]      ready_vec;
  logic                  free_found;
  logic [IW-1:0]         free_idx;
  logic                  sel_found;
  logic [IW-1:0]         sel_idx;
  logic [RS_ROB_W-1:0]   alu_src;
  logic [RS_ROB_W-1:0]   lsu_src;

  assign alu_src = RS_ROB_W'(cdb_alu_src);
  assign lsu_src = RS_ROB_W'(cdb_lsu_src);

  // Per-entry, per-operand wake-up comparators and status bits
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_opnd_t op1_w;
    rs_opnd_t op2_w;

    assign op1_w = wake_opnd(ent_q[g].op1, cdb_alu_valid, alu_src, cdb_alu_val,
                             cdb_lsu_valid, lsu_src, cdb_lsu_val);
    assign op2_w = wake_opnd(ent_q[g].op2, cdb_alu_valid, alu_src, cdb_alu_val,
                             cdb_lsu_valid, lsu_src, cdb_lsu_val);

    always_comb begin
      ent_wake[g] = ent_q[g];
      if (ent_q[g].busy) begin
        ent_wake[g].op1 = op1_w;
        ent_wake[g].op2 = op2_w;
      end
    end

    assign busy_vec[g]  = ent_q[g].busy;
    assign ready_vec[g] = ent_q[g].busy && (ent_q[g].op1.dep == ROB_NONE) &&
                          (ent_q[g].op2.dep == ROB_NONE);
  end

  rs_select #(.N(DEPTH)) u_free_sel (
    .req   (~busy_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_select #(.N(DEPTH)) u_issue_sel (
    .req   (ready_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign rs_full = &busy_vec;

  // Incoming op with same-cycle CDB bypass on both operands
  always_comb begin
    disp_ent         = '0;
    disp_ent.busy    = 1'b1;
    disp_ent.opt     = RS_OPT_W'(disp_opt);
    disp_ent.imm     = disp_imm;
    disp_ent.rob_idx = RS_ROB_W'(disp_rob_idx);
    disp_ent.op1     = wake_opnd('{val: disp_val1, dep: RS_ROB_W'(disp_dep1)},
                                 cdb_alu_valid, alu_src, cdb_alu_val,
                                 cdb_lsu_valid, lsu_src, cdb_lsu_val);
    disp_ent.op2     = wake_opnd('{val: disp_val2, dep: RS_ROB_W'(disp_dep2)},
                                 cdb_alu_valid, alu_src, cdb_alu_val,
                                 cdb_lsu_valid, lsu_src, cdb_lsu_val);
  end

  // Flush beats everything except reset; a stalled cycle holds all state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      rs_valid   <= 1'b0;
      rs_opt     <= '0;
      rs_val1    <= '0;
      rs_val2    <= '0;
      rs_imm     <= '0;
      rs_rob_idx <= '0;
    end else if (rob_flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i].busy <= 1'b0;
      rs_valid <= 1'b0;
    end else if (rdy) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_wake[i];
      if (sel_found) begin
        ent_q[sel_idx].busy <= 1'b0;
        rs_valid   <= 1'b1;
        rs_opt     <= OPT_W'(ent_q[sel_idx].opt);
        rs_val1    <= ent_q[sel_idx].op1.val;
        rs_val2    <= ent_q[sel_idx].op2.val;
        rs_imm     <= ent_q[sel_idx].imm;
        rs_rob_idx <= ROB_W'(ent_q[sel_idx].rob_idx);
      end else begin
        rs_valid <= 1'b0;
      end
      if (disp_valid && free_found) ent_q[free_idx] <= disp_ent;
    end
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the integer ALU. It buffers dispatched ALU and branch micro-ops and captures missing operands from the common data bus (CDB). Each cycle it issues one operand-complete entry to the combinational ALU through a registered issue port. It sits between the dispatcher and the ALU; the ALU's CDB result feeds back into this block's wake-up logic.

## Interface
Parameters:
- DEPTH, 8: number of station entries (power of two, 2..16)
- ROB_W, 4: ROB index width; index 0 means "no dependency / no ROB target"
- OPT_W, 6: opcode width, from the shared opcode enumeration

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rdy  in  1  global ready; low freezes all state
- rob_flush  in  1  mispredict flush; empties the station
- disp_valid  in  1  dispatch request; ignored while rs_full is high
- disp_opt  in  OPT_W  opcode
- disp_val1, disp_val2, disp_imm  in  32 each  operand values and immediate
- disp_dep1, disp_dep2  in  ROB_W each  producer ROB index of operand 1 / 2 (0 means value already valid)
- disp_rob_idx  in  ROB_W  destination ROB entry
- rs_full  out  1  no free entry (combinational from entry state)
- cdb_alu_valid, cdb_lsu_valid  in  1 each  CDB broadcast strobes
- cdb_alu_src, cdb_lsu_src  in  ROB_W each  broadcasting ROB index
- cdb_alu_val, cdb_lsu_val  in  32 each  broadcast values
- rs_valid  out  1  issue strobe to the ALU
- rs_opt, rs_val1, rs_val2, rs_imm, rs_rob_idx  out  as dispatch  issued entry fields

## Operation
- Each entry holds: busy, opt, val1, dep1, val2, dep2, imm, rob_idx.
- An entry is ready when busy, dep1==0 and dep2==0.
- **Dispatch:** when disp_valid and !rs_full, write the lowest-index free entry and set it busy.
- **Dispatch bypass:** if disp_depN is nonzero and equals a valid CDB src in the same cycle, store the CDB value and set depN=0.
- **Wake-up:** for every busy entry, each depN!=0 matching a valid CDB src captures that source's value and clears depN.
  - If both CDB sources match the same depN, the ALU source wins.
  - depN==0 never matches.
- **Select:** pick the lowest-index ready entry, judged on state at the start of the cycle. Next cycle: rs_valid=1, rs_* hold that entry's fields, and the entry's busy is cleared. With no ready entry, rs_valid=0 and rs_* hold their previous values.
- **Flush:** rob_flush clears every busy bit and sets rs_valid=0. It overrides dispatch, wake-up and issue in the same cycle.
- **Stall:** when rdy=0, no state changes, dispatch is ignored, and the outputs hold. rob_flush and rst are still honoured while rdy=0.
- **Reset values:** all busy=0, rs_valid=0, and rs_opt, rs_val1, rs_val2, rs_imm, rs_rob_idx all 0. rs_full=0 after reset.

## Timing
- Issue latency: an entry dispatched in cycle t with both operands ready (or bypassed) is issuable in t+1, so rs_valid rises in t+2.
- Wake-up in cycle t makes the entry issuable in t+1.
- Throughput: one issue per cycle.
- A slot freed by issue in cycle t is visible in rs_full from t+1. Dispatch can refill it in t+1.
- Full boundary: with DEPTH busy entries, rs_full=1 and disp_valid is dropped; the dispatcher must hold the op. Simultaneous issue and dispatch while full is not allowed; the dispatch waits one cycle.
- Reset or flush asserted mid-stream takes effect at the next edge. In-flight CDB matches in that cycle are discarded.
- rs_* outputs are registers. The ALU path is purely combinational from them, so ALU → CDB → wake-up forms a one-cycle loop. A dependent op can issue back-to-back, two cycles after its producer.

## Structure
- Shared package/header:
  - word, ROB-index and opcode widths, and the opcode enumeration (shared with the ALU and decoder)
  - the "ROB index 0 = none" constant
  - the entry record typedef
- One sub-module, `rs_select`: a parameterised lowest-index priority encoder, used twice (free-slot search and ready-entry search). It outputs found and index.
- Wake-up comparators are generated per entry per operand.

## Test plan
- Reset, then dispatch ADD (val1=5, val2=7, deps 0, rob 3) in cycle 1 → cycle 3: rs_valid=1, rs_opt=ADD, rs_val1=5, rs_val2=7, rs_rob_idx=3. Cycle 4: rs_valid=0.
- Dispatch ADDI with dep1=2, imm=4; cycle 5 cdb_alu_valid=1, src=2, val=0x10 → next cycle issue with rs_val1=0x10. Repeat with the broadcast in the dispatch cycle (bypass): same result.
- Fill 8 entries all waiting on dep1=6 → rs_full=1, a 9th disp_valid is ignored. One CDB broadcast of src 6 → entries 0..7 issue on 8 consecutive cycles in index order. rs_full=0 one cycle after the first issue.
- ALU and LSU CDB broadcast the same cycle to one entry (dep1=4 from LSU, dep2=5 from ALU) → both captured, issue next cycle with both values correct.
- Four busy entries and rob_flush=1 together with a disp_valid → next cycle rs_valid=0, rs_full=0, and nothing issues afterward without new dispatch.
- rdy=0 for 3 cycles with a ready entry and a CDB broadcast → no issue, no capture. rdy=1 → issue resumes with pre-stall values.
